// File: rtl/cdc_loopback_fifo_if.sv
// Byte-stream handshake bundle between usb_cdc bulk endpoints and the loopback FIFO.
// slave = FIFO side (consumes OUT stream, produces IN stream); master = usb_cdc side.
interface cdc_loopback_fifo_if;
  logic [7:0] out_data_i;
  logic       out_valid_i;
  logic       out_ready_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i;

  modport slave (
    input  out_data_i, out_valid_i, in_ready_i,
    output out_ready_o, in_data_o, in_valid_o
  );

  modport master (
    output out_data_i, out_valid_i, in_ready_i,
    input  out_ready_o, in_data_o, in_valid_o
  );
endinterface

// File: rtl/cdc_loopback_fifo.sv
// Echo FIFO between usb_cdc OUT and IN bulk endpoints, with idle-sleep indication.
// Optional: define LOOPBACK_UPCASE_EN to store 'a'..'z' as upper case at write time.
module cdc_loopback_fifo #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned IDLE_CYCLES = 12000000
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  cdc_loopback_fifo_if.slave    bus,
  output logic                  sleep_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 24;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  typedef enum logic {ACTIVE = 1'b0, SLEEP = 1'b1} state_t;

  logic             run_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [7:0]       mem [DEPTH];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             sleep_q;

  logic empty_c;
  logic full_c;
  logic out_fire_c;
  logic in_fire_c;

  // Byte transformation applied on the write path only, so it adds no latency.
  function automatic logic [7:0] store_byte(input logic [7:0] b);
`ifdef LOOPBACK_UPCASE_EN
    if ((b >= 8'h61) && (b <= 8'h7a)) begin
      return b - 8'h20;
    end
    return b;
`else
    return b;
`endif
  endfunction

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  assign bus.out_ready_o = run_q & ~full_c;
  assign bus.in_valid_o  = ~empty_c;
  assign bus.in_data_o   = empty_c ? 8'h00 : mem[rd_ptr_q[DEPTH_LOG2-1:0]];

  assign out_fire_c = bus.out_valid_i & bus.out_ready_o;
  assign in_fire_c  = bus.in_valid_o & bus.in_ready_i;

  assign level_o = PTR_W'(wr_ptr_q - rd_ptr_q);
  assign sleep_o = sleep_q;

  // Run flag holds off the OUT endpoint for one cycle after reset release.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Storage has no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (out_fire_c) begin
      mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= store_byte(bus.out_data_i);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (out_fire_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (in_fire_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Sleep FSM state and idle counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ACTIVE;
      idle_cnt_q <= '0;
      sleep_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      sleep_q    <= (state_d == SLEEP);
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ACTIVE: begin
        if (out_fire_c || in_fire_c || !empty_c) begin
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
          if (idle_cnt_q == IDLE_LAST) begin
            state_d = SLEEP;
          end
        end
      end
      SLEEP: begin
        // Only new OUT traffic wakes; IN-side readiness alone does not.
        if (out_fire_c) begin
          state_d    = ACTIVE;
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ACTIVE;
        idle_cnt_d = '0;
      end
    endcase
  end

endmodule
